// File: rtl/arb_pkg.sv
// Shared types and defaults for the round-robin burst arbiter.
// Optional watchdog is enabled by defining ARB_TIMEOUT_EN.
package arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  localparam int N_REQ_DEF     = 4;
  localparam int MAX_BURST_DEF = 8;
  localparam int TIMEOUT_DEF   = 16;

  // Index width that never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first unmasked request at or after ptr_i+1.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IW    = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  input  logic [N_REQ-1:0] mask_i,
  output logic [N_REQ-1:0] win_o,
  output logic [IW-1:0]    idx_o,
  output logic             found_o
);

  logic [N_REQ-1:0] cand;
  logic             hit;

  assign cand = req_i & ~mask_i;

  always_comb begin
    win_o = '0;
    idx_o = '0;
    hit   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      int c;
      c = (int'(ptr_i) + 1 + k) % N_REQ;
      if (!hit && cand[c]) begin
        hit      = 1'b1;
        win_o[c] = 1'b1;
        idx_o    = IW'(c);
      end
    end
    found_o = hit;
  end

endmodule

// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter with registered one-hot grant and per-grant beat counting.
// Define ARB_TIMEOUT_EN to build the idle-grant watchdog and drive timeout.
module rr_burst_arbiter
  import arb_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF,
  localparam int IW       = idx_w(N_REQ),
  localparam int CW       = $clog2(MAX_BURST + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             beat,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    grant_idx,
  output logic             grant_valid,
  output logic [CW-1:0]    beat_cnt,
  output logic             timeout,
  output arb_state_t       dbg_state
);

  // Handshake: a requester holds req high for its whole burst; beat means the
  // resource accepted one transfer from the current holder in that cycle.

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             tmo_q, tmo_d;

  logic [N_REQ-1:0] pick_mask;
  logic [N_REQ-1:0] pick_win;
  logic [IW-1:0]    pick_idx;
  logic             pick_found;

  logic             holder_req;
  logic [CW-1:0]    cnt_inc;
  logic             burst_hit;
  logic             wd_hit;
  logic             release_now;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .mask_i  (pick_mask),
    .win_o   (pick_win),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle_q, idle_d;
  logic [TW-1:0] idle_inc;

  assign idle_inc = idle_q + TW'(1);
  assign wd_hit   = (state_q == ARB_BUSY) && !beat && (idle_inc == TW'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) idle_q <= '0;
    else     idle_q <= idle_d;
  end
`else
  wire unused_timeout_cfg = TIMEOUT[0];
  assign wd_hit = 1'b0;
`endif

  assign holder_req  = req[idx_q];
  assign cnt_inc     = (cnt_q == CW'(MAX_BURST)) ? cnt_q : cnt_q + CW'(1);
  assign burst_hit   = beat && (cnt_inc == CW'(MAX_BURST));
  assign release_now = !holder_req || burst_hit || wd_hit;
  // The holder never competes against itself when its grant is released.
  assign pick_mask   = (state_q == ARB_BUSY) ? grant_q : '0;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
`ifdef ARB_TIMEOUT_EN
    idle_d  = idle_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        cnt_d = '0;
`ifdef ARB_TIMEOUT_EN
        idle_d = '0;
`endif
        if (pick_found) begin
          state_d = ARB_BUSY;
          grant_d = pick_win;
          idx_d   = pick_idx;
          ptr_d   = pick_idx;
        end
      end
      ARB_BUSY: begin
        cnt_d = beat ? cnt_inc : cnt_q;
`ifdef ARB_TIMEOUT_EN
        idle_d = beat ? '0 : idle_inc;
`endif
        if (release_now) begin
          tmo_d = wd_hit;
          if (pick_found) begin
            grant_d = pick_win;
            idx_d   = pick_idx;
            ptr_d   = pick_idx;
            cnt_d   = '0;
`ifdef ARB_TIMEOUT_EN
            idle_d  = '0;
`endif
          end else if (holder_req) begin
            cnt_d = '0;
`ifdef ARB_TIMEOUT_EN
            idle_d = '0;
`endif
          end else begin
            // Final count stays visible for the one idle cycle that follows.
            state_d = ARB_IDLE;
            grant_d = '0;
            idx_d   = '0;
          end
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= IW'(N_REQ - 1);
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = idx_q;
  assign grant_valid = |grant_q;
  assign beat_cnt    = cnt_q;
  assign timeout     = tmo_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Directed self-checking bench for rr_burst_arbiter (default parameters).
// The watchdog section follows ARB_TIMEOUT_EN, matching the RTL build.
module tb_rr_burst_arbiter;
  import arb_pkg::*;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       beat;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       grant_valid;
  logic [3:0] beat_cnt;
  logic       timeout;
  arb_state_t dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  rr_burst_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .beat        (beat),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .beat_cnt    (beat_cnt),
    .timeout     (timeout),
    .dbg_state   (dbg_state)
  );

  // Clock and reset helpers
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = '0;
    beat = 1'b0;
    tick();
    rst  = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_grant"}, 32'(grant), 32'h0);
    check({tag, "_idx"},   32'(grant_idx), 32'h0);
    check({tag, "_valid"}, 32'(grant_valid), 32'h0);
    check({tag, "_cnt"},   32'(beat_cnt), 32'h0);
    check({tag, "_tmo"},   32'(timeout), 32'h0);
    check({tag, "_state"}, 32'(dbg_state), 32'(ARB_IDLE));
  endtask

  initial begin
    rst  = 1'b1;
    req  = '0;
    beat = 1'b0;
    tick();
    tick();
    check_idle("reset");
    rst = 1'b0;

    // Basic grant then direct handover without idle gap
    req = 4'b0101;
    tick();
    check("t1_grant0", 32'(grant), 32'h1);
    check("t1_idx0", 32'(grant_idx), 32'h0);
    check("t1_valid", 32'(grant_valid), 32'h1);
    check("t1_state", 32'(dbg_state), 32'(ARB_BUSY));
    req = 4'b0100;
    tick();
    check("t1_grant2", 32'(grant), 32'h4);
    check("t1_idx2", 32'(grant_idx), 32'h2);
    req = 4'b0000;
    tick();
    check("t1_release", 32'(grant), 32'h0);
    check("t1_state_idle", 32'(dbg_state), 32'(ARB_IDLE));

    // Rotation with one-beat bursts
    do_reset();
    req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      logic [3:0] exp_g;
      exp_g = 4'b0001 << (k % 4);
      check($sformatf("rot%0d_grant", k), 32'(grant), 32'(exp_g));
      check($sformatf("rot%0d_cnt", k), 32'(beat_cnt), 32'h0);
      req  = 4'b1111 ^ exp_g;
      beat = 1'b1;
      tick();
    end
    req  = '0;
    beat = 1'b0;
    tick();
    check("rot_end_idle", 32'(grant), 32'h0);

    // Burst limit: regrant of the lone requester, then hand over to 3
    do_reset();
    req = 4'b0100;
    tick();
    check("bl_grant", 32'(grant), 32'h4);
    check("bl_cnt0", 32'(beat_cnt), 32'h0);
    beat = 1'b1;
    for (int i = 1; i < 8; i++) begin
      tick();
      check($sformatf("bl_cnt%0d", i), 32'(beat_cnt), 32'(i));
      check($sformatf("bl_hold%0d", i), 32'(grant), 32'h4);
    end
    tick();
    check("bl_regrant", 32'(grant), 32'h4);
    check("bl_regrant_cnt", 32'(beat_cnt), 32'h0);
    req = 4'b1100;
    for (int i = 1; i < 8; i++) begin
      tick();
      check($sformatf("bl2_cnt%0d", i), 32'(beat_cnt), 32'(i));
      check($sformatf("bl2_nopreempt%0d", i), 32'(grant), 32'h4);
    end
    tick();
    check("bl2_handover", 32'(grant), 32'h8);
    check("bl2_idx", 32'(grant_idx), 32'h3);
    check("bl2_cnt", 32'(beat_cnt), 32'h0);

    // Beat coincident with request drop, then beats while idle
    req = 4'b1000;
    tick();
    check("drop_cnt1", 32'(beat_cnt), 32'h1);
    req = 4'b0000;
    tick();
    check("drop_grant", 32'(grant), 32'h0);
    check("drop_cnt2", 32'(beat_cnt), 32'h2);
    tick();
    check("idle_beat_cnt", 32'(beat_cnt), 32'h0);
    tick();
    check("idle_beat_cnt2", 32'(beat_cnt), 32'h0);
    check("idle_beat_grant", 32'(grant), 32'h0);
    beat = 1'b0;

    // Idle-grant watchdog
    do_reset();
    req = 4'b0011;
    tick();
    check("wd_grant", 32'(grant), 32'h1);
`ifdef ARB_TIMEOUT_EN
    for (int k = 1; k < 16; k++) begin
      tick();
      check($sformatf("wd_hold%0d", k), 32'(grant), 32'h1);
      check($sformatf("wd_tmo%0d", k), 32'(timeout), 32'h0);
    end
    tick();
    check("wd_move", 32'(grant), 32'h2);
    check("wd_pulse", 32'(timeout), 32'h1);
    tick();
    check("wd_pulse_end", 32'(timeout), 32'h0);
    check("wd_new_hold", 32'(grant), 32'h2);
`else
    for (int k = 1; k <= 100; k++) begin
      tick();
      check($sformatf("nowd_hold%0d", k), 32'(grant), 32'h1);
      check($sformatf("nowd_tmo%0d", k), 32'(timeout), 32'h0);
    end
`endif

    // Reset in the middle of a burst
    do_reset();
    req = 4'b0001;
    tick();
    beat = 1'b1;
    tick();
    tick();
    check("mid_cnt", 32'(beat_cnt), 32'h2);
    rst = 1'b1;
    tick();
    check_idle("mid_rst");
    rst  = 1'b0;
    beat = 1'b0;
    req  = 4'b1001;
    tick();
    check("post_rst_grant", 32'(grant), 32'h1);
    check("post_rst_idx", 32'(grant_idx), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_burst_arbiter.md
# rr_burst_arbiter

Round-robin arbiter sharing one single-ported resource among `N_REQ` requesters. It issues a registered one-hot grant and tracks accepted beats from the resource. It revokes the grant when the holder drops its request or reaches `MAX_BURST` beats. It sits between the requester ports and the shared resource's select/mux logic.

## Interface
- `N_REQ`, 4: number of requesters, ≥2.
- `MAX_BURST`, 8: beats per grant before forced release, ≥1.
- `TIMEOUT`, 16: idle-grant cycles before revocation, ≥2 (used only with `ARB_TIMEOUT_EN`).
- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req`  in  N_REQ: level request per requester; holder keeps it high for the whole burst.
- `beat`  in  1: shared resource accepted a transfer from the current holder this cycle.
- `grant`  out  N_REQ: registered one-hot grant; all-zero when idle.
- `grant_idx`  out  $clog2(N_REQ): index of holder; 0 when idle.
- `grant_valid`  out  1: OR of `grant`.
- `beat_cnt`  out  $clog2(MAX_BURST+1): beats accepted in the current grant.
- `timeout`  out  1: one-cycle pulse on watchdog revocation.

## Operation
- FSM `ARB_IDLE`, `ARB_BUSY`.
- Reset: every output is 0, state is `ARB_IDLE`, and the last-grant pointer is `N_REQ-1`, so requester 0 has top priority.
- `ARB_IDLE`: if any `req` is high, pick the first requester at or after pointer+1 (wrapping modulo `N_REQ`). Register its grant, go to `ARB_BUSY`, set pointer to the winner, clear `beat_cnt`.
- `ARB_BUSY`: `beat` increments `beat_cnt` (saturating at `MAX_BURST`). `beat` while idle is ignored.
- A release condition is any of:
  - holder's `req` is sampled low;
  - `beat` brings `beat_cnt` to `MAX_BURST`;
  - watchdog expiry.
- On release, arbitrate in the same cycle over the current `req` vector, with the releasing requester masked:
  - if another requester wins, hand over directly with no idle cycle and clear `beat_cnt`;
  - if nobody else requests and the holder still requests (burst limit or timeout case), regrant the holder and clear `beat_cnt`;
  - otherwise return to `ARB_IDLE`.
- Simultaneous `beat` and `req` drop: the beat is counted (visible for that cycle only), then the grant is released.
- Simultaneous burst limit and `req` drop: a single release; the pointer advances once.
- `rst` mid-burst: grant drops on the next edge with no handshake; in-flight beat is discarded.
- Requests from non-holders never preempt an active grant.

## Timing
- Grant latency: `req` high at cycle t in `ARB_IDLE` → `grant` high at t+1.
- Release latency: release condition at cycle t → old grant low at t+1, new grant (if any) high at t+1.
- `beat_cnt` updates at t+1 for a `beat` at t.
- `timeout` is asserted in the cycle the revoked grant is dropped.
- Outputs are registered only; there is no combinational path from `req` or `beat` to any output.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - an idle counter counts consecutive `ARB_BUSY` cycles with `beat` low and clears on any `beat` or new grant;
  - reaching `TIMEOUT` triggers release plus a `timeout` pulse.
- `ARB_TIMEOUT_EN` undefined:
  - no counter is built and `timeout` is tied 0;
  - a grant is held indefinitely while `req` stays high below the burst limit.

## Structure
- Package `arb_pkg`: state enum `arb_state_t` (`ARB_IDLE`, `ARB_BUSY`), default constants for `N_REQ`, `MAX_BURST`, `TIMEOUT`, and an index-width function.
- Sub-module `rr_pick`: combinational rotating-priority picker.
  - Inputs: `req` vector, pointer, mask.
  - Outputs: one-hot winner, index, found.
  - Instantiated once.

## Test plan
- Reset then `req`=0b0101 → `grant`=0b0001 one cycle later; drop `req[0]` → `grant`=0b0100 next cycle, no idle gap.
- All four requesting, 1-beat bursts → grant order 0,1,2,3,0, each for exactly one beat.
- `MAX_BURST`=8, only `req[2]` high, `beat` every cycle → `beat_cnt` reaches 8, then requester 2 is regranted with `beat_cnt`=0. Same case with `req[3]` also high → grant moves to 3.
- `beat` and `req` drop in the same cycle → `beat_cnt` increments, grant drops next cycle; `beat` while idle → `beat_cnt` stays 0.
- With `ARB_TIMEOUT_EN` and `TIMEOUT`=16: holder silent for 16 cycles → `timeout` pulses once, grant moves to the next requester. Without the macro: grant held for 100 silent cycles and `timeout` stays 0.
- `rst` asserted mid-burst → all outputs 0 next cycle; with `req[3]` high after reset, 0 and 3 both requesting → grant goes to 0.
